// File: rtl/fc_argmax.sv
// ---------------------------------------------------------------------------
// fc_argmax
//
// Streaming arg-max over one frame of N_CLASS unsigned class scores coming
// from the fc2 layer.  Scores arrive one per accepted beat on a valid/ready
// stream.  Once the last score of a frame has been taken, the index of the
// largest score is presented on a valid/ready result port.  On a tie, the
// earliest index wins.
//
// Parameters
//   I_WIDTH  width of one class score (fc2 ReLU output width)
//   N_CLASS  number of scores per frame, 2..1024
//   C_WIDTH  width of a class index, $clog2(N_CLASS)
//
// Ports
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   s_valid  upstream score valid
//   s_ready  block can accept a score (registered)
//   s_data   unsigned score
//   m_valid  result valid (registered)
//   m_ready  downstream accepts the result
//   m_class  index of the winning class
//   m_score  winning score, present only when FC_ARGMAX_SCORE_EN is defined
//
// Build option
//   FC_ARGMAX_SCORE_EN  adds the m_score output port.  The winning score is
//                       tracked internally either way, because the compare
//                       needs it.
// ---------------------------------------------------------------------------
module fc_argmax #(
  parameter  int I_WIDTH = 22,
  parameter  int N_CLASS = 10,
  localparam int C_WIDTH = $clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [I_WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [C_WIDTH-1:0] m_class
`ifdef FC_ARGMAX_SCORE_EN
  ,
  output logic [I_WIDTH-1:0] m_score
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  localparam logic [C_WIDTH-1:0] LAST_IDX = C_WIDTH'(N_CLASS - 1);

  state_t             r_state;
  logic [C_WIDTH-1:0] r_idx;
  logic [I_WIDTH-1:0] r_bestScore;
  logic [C_WIDTH-1:0] r_bestIdx;
  logic               r_sReady;
  logic               r_mValid;

  logic               w_accept;
  logic               w_takeBeat;

  // A beat is taken only while we advertise ready.  The first beat of a
  // frame always loads the best registers.  Later beats load them only on a
  // strictly greater score, so on a tie the earlier index is kept.
  assign w_accept   = s_valid && r_sReady;
  assign w_takeBeat = (r_idx == '0) || (s_data > r_bestScore);

  // Single FSM process.  s_ready and m_valid are registered copies of the
  // state, so neither depends combinationally on s_valid or m_ready.  In
  // COLLECT the index counter advances on every accepted beat and wraps to
  // zero on the last beat of the frame, which also moves the FSM to RESULT.
  // The result is held until the downstream handshake, and then the FSM
  // returns to COLLECT.  Because of this there is always at least one idle
  // cycle between frames.  Reset has priority over any handshake in the same
  // cycle, and it drops any partial frame or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_bestScore <= '0;
      r_bestIdx   <= '0;
      r_sReady    <= 1'b1;
      r_mValid    <= 1'b0;
    end else if (r_state == COLLECT) begin
      if (w_accept) begin
        if (w_takeBeat) begin
          r_bestScore <= s_data;
          r_bestIdx   <= r_idx;
        end
        if (r_idx == LAST_IDX) begin
          r_idx    <= '0;
          r_state  <= RESULT;
          r_sReady <= 1'b0;
          r_mValid <= 1'b1;
        end else begin
          r_idx <= r_idx + C_WIDTH'(1);
        end
      end
    end else begin
      if (r_mValid && m_ready) begin
        r_state  <= COLLECT;
        r_sReady <= 1'b1;
        r_mValid <= 1'b0;
      end
    end
  end

  // The outputs come straight from registers.  The result fields stay
  // stable for the whole time RESULT is held, because the best registers
  // only change on accepted beats.
  assign s_ready = r_sReady;
  assign m_valid = r_mValid;
  assign m_class = r_bestIdx;
`ifdef FC_ARGMAX_SCORE_EN
  assign m_score = r_bestScore;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// ---------------------------------------------------------------------------
// tb_fc_argmax
//
// Self-checking bench for fc_argmax.  The bench drives inputs and samples
// outputs on the falling clock edge.  Expected results come from a table of
// fixed frames with hand-computed answers, and from a behavioural arg-max
// model applied to random frames.  Hand-written sequences cover three cases:
// result backpressure, reset mid-frame, and reset while a result is pending.
// Build with and without FC_ARGMAX_SCORE_EN.
// ---------------------------------------------------------------------------
module tb_fc_argmax;

  localparam int I_WIDTH = 22;
  localparam int N_CLASS = 10;
  localparam int C_WIDTH = $clog2(N_CLASS);
  localparam logic [I_WIDTH-1:0] MAX_SCORE = '1;

  typedef logic [N_CLASS-1:0][I_WIDTH-1:0] frame_t;

  typedef struct {
    frame_t            scores;
    int                expClass;
    logic [I_WIDTH-1:0] expScore;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [I_WIDTH-1:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic [C_WIDTH-1:0] m_class;
`ifdef FC_ARGMAX_SCORE_EN
  logic [I_WIDTH-1:0] m_score;
`endif

  int checks;
  int errors;

  fc_argmax #(
    .I_WIDTH(I_WIDTH),
    .N_CLASS(N_CLASS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_class(m_class)
`ifdef FC_ARGMAX_SCORE_EN
    ,
    .m_score(m_score)
`endif
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and records the result.  Each call counts as one
  // check, and each mismatch adds one error.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference arg-max model.  It first finds the largest value, then
  // returns the first index holding that value.
  task automatic refModel(input frame_t f, output int cls,
                          output logic [I_WIDTH-1:0] best);
    best = '0;
    for (int i = 0; i < N_CLASS; i++)
      if (f[i] > best) best = f[i];
    cls = -1;
    for (int i = N_CLASS - 1; i >= 0; i--)
      if (f[i] == best) cls = i;
  endtask

  // Sends the first nBeats scores of a frame.  A random number of idle
  // cycles (0..gapMax) goes before each beat, with garbage on s_data.  The
  // task returns on the falling edge just after the last accepted beat,
  // with s_valid low.
  task automatic applyStimulus(input frame_t f, input int gapMax, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      int gap;
      int n;
      gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      repeat (gap) begin
        s_valid = 1'b0;
        s_data  = I_WIDTH'($urandom);
        @(negedge clk);
      end
      n = 0;
      while (!s_ready && n < 50) begin
        s_valid = 1'b0;
        @(negedge clk);
        n++;
      end
      if (!s_ready) begin
        checkOutput("sReadyTimeout", 32'(s_ready), 32'd1);
      end
      s_valid = 1'b1;
      s_data  = f[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Checks the result one cycle after the last accept.  It then checks that
  // the handshake, with m_ready high, ends RESULT after exactly one cycle.
  task automatic checkResult(input string tag, input int expClass,
                             input logic [I_WIDTH-1:0] expScore);
    checkOutput({tag, ".mValid"}, 32'(m_valid), 32'd1);
    checkOutput({tag, ".sReadyLow"}, 32'(s_ready), 32'd0);
    checkOutput({tag, ".mClass"}, 32'(m_class), 32'(expClass));
`ifdef FC_ARGMAX_SCORE_EN
    checkOutput({tag, ".mScore"}, 32'(m_score), 32'(expScore));
`else
    if (expScore != expScore) $display("[TB] unreachable");
`endif
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".mValidDrop"}, 32'(m_valid), 32'd0);
    checkOutput({tag, ".sReadyBack"}, 32'(s_ready), 32'd1);
  endtask

  // Checks that the outputs show the reset values.
  task automatic checkReset(input string tag);
    checkOutput({tag, ".sReady"}, 32'(s_ready), 32'd1);
    checkOutput({tag, ".mValid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, ".mClass"}, 32'(m_class), 32'd0);
`ifdef FC_ARGMAX_SCORE_EN
    checkOutput({tag, ".mScore"}, 32'(m_score), 32'd0);
`endif
  endtask

  // Builds a random frame.  Narrow score ranges make ties likely, and wide
  // ranges exercise the full-width compare.
  task automatic randomFrame(output frame_t f);
    bit narrow;
    narrow = $urandom_range(0, 1) == 1;
    for (int i = 0; i < N_CLASS; i++)
      f[i] = narrow ? I_WIDTH'($urandom_range(0, 3)) : I_WIDTH'($urandom);
  endtask

  vec_t vecs[4];
  int   tbl[4][N_CLASS];
  int   expC;
  logic [I_WIDTH-1:0] expS;
  frame_t fr;
  frame_t frB;

  // Main test sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkReset("reset");

    // Fixed frames with hand-computed answers.
    tbl = '{'{5, 9, 3, 9, 0, 1, 2, 8, 7, 6},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4194303},
            '{7, 1, 7, 2, 3, 7, 0, 6, 5, 4}};
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N_CLASS; i++)
        vecs[k].scores[i] = I_WIDTH'(tbl[k][i]);
    vecs[0].expClass = 1; vecs[0].expScore = 22'd9;
    vecs[1].expClass = 0; vecs[1].expScore = 22'd0;
    vecs[2].expClass = 9; vecs[2].expScore = 22'h3FFFFF;
    vecs[3].expClass = 0; vecs[3].expScore = 22'd7;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(vecs[k].scores, 0, N_CLASS);
      checkResult($sformatf("vec%0d", k), vecs[k].expClass, vecs[k].expScore);
    end

    // Random frames with random gaps, checked against the model.
    for (int k = 0; k < 16; k++) begin
      randomFrame(fr);
      refModel(fr, expC, expS);
      applyStimulus(fr, int'($urandom_range(0, 3)), N_CLASS);
      checkResult($sformatf("rand%0d", k), expC, expS);
    end

    // Backpressure: the result must stay stable while offered beats are
    // refused.
    randomFrame(fr);
    refModel(fr, expC, expS);
    m_ready = 1'b0;
    applyStimulus(fr, 0, N_CLASS);
    checkOutput("bp.mValid", 32'(m_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1;
      s_data  = MAX_SCORE;
      @(negedge clk);
      checkOutput($sformatf("bp.sReady%0d", c), 32'(s_ready), 32'd0);
      checkOutput($sformatf("bp.mValid%0d", c), 32'(m_valid), 32'd1);
      checkOutput($sformatf("bp.mClass%0d", c), 32'(m_class), 32'(expC));
`ifdef FC_ARGMAX_SCORE_EN
      checkOutput($sformatf("bp.mScore%0d", c), 32'(m_score), 32'(expS));
`endif
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.release", 32'(m_valid), 32'd0);
    randomFrame(fr);
    refModel(fr, expC, expS);
    applyStimulus(fr, 1, N_CLASS);
    checkResult("bpNext", expC, expS);

    // Reset after four gapped accepts, asserted together with a beat.  The
    // full-scale score must be discarded.
    fr[0] = 22'd1; fr[1] = 22'd2; fr[2] = MAX_SCORE; fr[3] = 22'd3;
    applyStimulus(fr, 3, 4);
    s_valid = 1'b1;
    s_data  = MAX_SCORE;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    checkReset("midReset");
    for (int i = 0; i < N_CLASS; i++) frB[i] = I_WIDTH'($urandom_range(0, 50));
    frB[6] = 22'd77;
    refModel(frB, expC, expS);
    applyStimulus(frB, 2, N_CLASS);
    checkResult("postReset", expC, expS);

    // Reset while a result is pending drops that result.
    m_ready = 1'b0;
    applyStimulus(vecs[2].scores, 0, N_CLASS);
    checkOutput("resPend.mValid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("resultReset");
    m_ready = 1'b1;
    applyStimulus(vecs[0].scores, 0, N_CLASS);
    checkResult("afterResultReset", vecs[0].expClass, vecs[0].expScore);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 The block SHALL have parameter I_WIDTH, default 22, giving the width of one class score, which equals the ReLU output width of an fc2 neuron.
REQ-002 The block SHALL have parameter N_CLASS, default 10, giving the number of scores per frame; legal range 2..1024.
REQ-003 The block SHALL have localparam C_WIDTH = $clog2(N_CLASS), the width of a class index.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-006 Port s_valid SHALL be an input, 1 bit: the upstream score is valid.
REQ-007 Port s_ready SHALL be an output, 1 bit: the block can accept a score.
REQ-008 Port s_data SHALL be an input, I_WIDTH bits: an unsigned score (a post-ReLU neuron output, never negative).
REQ-009 Port m_valid SHALL be an output, 1 bit: the result is valid.
REQ-010 Port m_ready SHALL be an input, 1 bit: downstream accepts the result.
REQ-011 Port m_class SHALL be an output, C_WIDTH bits: the index of the winning class.
REQ-012 Port m_score SHALL be an output, I_WIDTH bits: the winning score; it is present only when FC_ARGMAX_SCORE_EN is defined.

Function
REQ-013 The FSM SHALL have exactly two states, COLLECT and RESULT.
REQ-014 In COLLECT, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-015 In RESULT, s_ready SHALL be 0 and m_valid SHALL be 1.
REQ-016 A beat SHALL be accepted on a rising edge where s_valid and s_ready are both 1; only accepted beats change state.
REQ-017 An index counter idx (C_WIDTH bits) SHALL number beats 0..N_CLASS-1 within a frame and increment on each accepted beat.
REQ-018 On the first accepted beat (idx==0), best_score SHALL load s_data and best_idx SHALL load 0, unconditionally.
REQ-019 On each later accepted beat, if s_data > best_score (unsigned, strictly greater), best_score SHALL load s_data and best_idx SHALL load idx.
REQ-020 On a tie, the lower index SHALL be retained.
REQ-021 On the accepted beat with idx==N_CLASS-1, the FSM SHALL go to RESULT and idx SHALL wrap to 0; m_valid SHALL be 1 in the next cycle (latency 1 cycle from the last accept).
REQ-022 In RESULT, m_class and m_score SHALL hold stable until m_valid && m_ready.
REQ-023 When m_valid && m_ready, the FSM SHALL return to COLLECT in the next cycle; the next frame's first beat can be accepted then (at least one bubble between frames).
REQ-024 s_valid deasserting mid-frame SHALL stall without losing idx or the best_* registers; gaps of any length are legal.
REQ-025 No combinational path SHALL exist from s_valid or m_ready to s_ready or m_valid; both are registered from the FSM state.
REQ-026 m_class SHALL be driven from best_idx; m_score SHALL be driven from best_score.

Reset
REQ-027 While rst is 1 at a rising edge, the FSM SHALL go to COLLECT, idx SHALL go to 0, best_score SHALL go to 0 and best_idx SHALL go to 0.
REQ-028 Outputs after reset SHALL be s_ready=1, m_valid=0, m_class=0 and m_score=0.
REQ-029 Reset mid-frame or in RESULT SHALL discard the partial frame or pending result; the first beat after reset is idx 0 of a new frame.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-031 With FC_ARGMAX_SCORE_EN defined, port m_score SHALL exist and follow REQ-026.
REQ-032 Without FC_ARGMAX_SCORE_EN, port m_score SHALL be absent, and best_score SHALL still be kept internally for comparison.
REQ-033 m_class and the handshake behaviour SHALL be identical with and without FC_ARGMAX_SCORE_EN.

Verification
REQ-034 Scores 5,9,3,9,0,1,2,8,7,6 streamed back-to-back, m_ready=1 -> m_valid=1 for one cycle, one cycle after the 10th accept; m_class=1 (tie at index 3 not taken); m_score=9.
REQ-035 All ten scores 0 -> m_class=0, m_score=0.
REQ-036 Winner last: scores 0..0 then 22'h3FFFFF at idx 9 -> m_class=9, m_score=22'h3FFFFF (full-width unsigned compare).
REQ-037 Backpressure: m_ready=0 for 5 cycles after m_valid -> s_ready=0 and m_class stable throughout; s_valid beats offered during this time are not accepted; the frame after release is processed correctly.
REQ-038 Random s_valid gaps, then rst asserted after 4 accepts, then a full 10-beat frame -> the result reflects only the post-reset frame.
REQ-039 Regression runs SHALL pass with FC_ARGMAX_SCORE_EN defined and with it undefined.
